// File: rtl/nice_icb_mem_responder.sv
// nice_icb_mem_responder
// Word-addressed SRAM behind the NICE ICB memory channel. Commands are
// decoded and executed at the accept edge; the result is queued in a small
// circular response FIFO so responses leave in acceptance order under
// response backpressure. A backdoor word port preloads the SRAM, and three
// saturating counters track reads, writes and errored commands.
module nice_icb_mem_responder #(
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          RSP_FIFO_DEPTH = 2
) (
  input  logic                           nice_clk,
  input  logic                           nice_rst_n,
  input  logic                           icb_cmd_valid,
  output logic                           icb_cmd_ready,
  input  logic [31:0]                    icb_cmd_addr,
  input  logic                           icb_cmd_read,
  input  logic [31:0]                    icb_cmd_wdata,
  input  logic [3:0]                     icb_cmd_wmask,
  output logic                           icb_rsp_valid,
  input  logic                           icb_rsp_ready,
  output logic [31:0]                    icb_rsp_rdata,
  output logic                           icb_rsp_err,
  input  logic                           bd_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] bd_idx,
  input  logic [31:0]                    bd_wdata,
  output logic [15:0]                    rd_cnt,
  output logic [15:0]                    wr_cnt,
  output logic [15:0]                    err_cnt
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = (RSP_FIFO_DEPTH > 2) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(RSP_FIFO_DEPTH + 1);
  localparam logic [32:0]      LIMIT_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(RSP_FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(RSP_FIFO_DEPTH);

  // Saturating +1 used by all event counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

  // Wrap a FIFO pointer modulo the queue depth (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [31:0]               mem_r [DEPTH_WORDS];
  logic [31:0]               fifo_rdata_r [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_DEPTH-1:0] fifo_err_r;
  logic [PTR_W-1:0]          wr_ptr_r;
  logic [PTR_W-1:0]          rd_ptr_r;
  logic [OCC_W-1:0]          occ_r;
  logic [OCC_W-1:0]          occ_nxt_s;
  logic                      cmd_ready_r;
  logic                      rsp_valid_r;
  logic [15:0]               rd_cnt_r;
  logic [15:0]               wr_cnt_r;
  logic [15:0]               err_cnt_r;

  logic [IDX_W-1:0]          idx_s;
  logic                      addr_err_s;
  logic                      accept_s;
  logic                      pop_s;
  logic                      wr_en_s;
  logic [31:0]               push_rdata_s;

  // Address decode, handshakes and the response word to be queued.
  always_comb begin
    // BASE_ADDR is aligned to the SRAM size, so for in-range addresses
    // (addr - BASE_ADDR) >> 2 reduces to these address bits.
    idx_s      = icb_cmd_addr[IDX_W+1:2];
    addr_err_s = (icb_cmd_addr[1:0] != 2'b00)
               || ({1'b0, icb_cmd_addr} <  {1'b0, BASE_ADDR})
               || ({1'b0, icb_cmd_addr} >= LIMIT_ADDR);
    accept_s   = icb_cmd_valid & cmd_ready_r;
    pop_s      = rsp_valid_r & icb_rsp_ready;
    wr_en_s    = accept_s & ~icb_cmd_read & ~addr_err_s;
    if (accept_s && icb_cmd_read && !addr_err_s) begin
      push_rdata_s = mem_r[idx_s];
    end else begin
      push_rdata_s = 32'h0000_0000;
    end
    case ({accept_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
      2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // SRAM write port: backdoor first, then enabled ICB bytes override it.
  always_ff @(posedge nice_clk) begin
    if (bd_we) begin
      mem_r[bd_idx] <= bd_wdata;
    end
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s && icb_cmd_wmask[b]) begin
        mem_r[idx_s][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
      end
    end
  end

  // Response queue, occupancy-derived handshake flags and event counters.
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fifo_rdata_r[i] <= 32'h0000_0000;
      end
      fifo_err_r  <= {RSP_FIFO_DEPTH{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      occ_r       <= {OCC_W{1'b0}};
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rd_cnt_r    <= 16'h0000;
      wr_cnt_r    <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      if (accept_s) begin
        fifo_rdata_r[wr_ptr_r] <= push_rdata_s;
        fifo_err_r[wr_ptr_r]   <= addr_err_s;
        wr_ptr_r               <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      occ_r       <= occ_nxt_s;
      cmd_ready_r <= (occ_nxt_s < FULL_OCC);
      rsp_valid_r <= (occ_nxt_s != {OCC_W{1'b0}});
      rd_cnt_r    <= sat_inc(rd_cnt_r,  accept_s & icb_cmd_read & ~addr_err_s);
      wr_cnt_r    <= sat_inc(wr_cnt_r,  wr_en_s);
      err_cnt_r   <= sat_inc(err_cnt_r, accept_s & addr_err_s);
    end
  end

  assign icb_cmd_ready = cmd_ready_r;
  assign icb_rsp_valid = rsp_valid_r;
  assign icb_rsp_rdata = fifo_rdata_r[rd_ptr_r];
  assign icb_rsp_err   = fifo_err_r[rd_ptr_r];
  assign rd_cnt        = rd_cnt_r;
  assign wr_cnt        = wr_cnt_r;
  assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_nice_icb_mem_responder.sv
// Bench for nice_icb_mem_responder: directed scenarios plus randomized
// traffic, all checked against a word-array / response-queue reference model.
module tb_nice_icb_mem_responder;

  logic        nice_clk;
  logic        nice_rst_n;
  logic        cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        icb_rsp_valid;
  logic        rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_wdata;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;

  nice_icb_mem_responder dut (
    .nice_clk      (nice_clk),
    .nice_rst_n    (nice_rst_n),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata),
    .icb_rsp_err   (icb_rsp_err),
    .bd_we         (bd_we),
    .bd_idx        (bd_idx),
    .bd_wdata      (bd_wdata),
    .rd_cnt        (rd_cnt),
    .wr_cnt        (wr_cnt),
    .err_cnt       (err_cnt)
  );

  initial nice_clk = 1'b0;
  always #5 nice_clk = ~nice_clk;

  int pass_cnt = 0;
  int check_cnt = 0;

  // Reference model: SRAM image, expected response queue {err, rdata}, counters.
  logic [31:0] mdl_mem [1024];
  logic [32:0] exp_q [$];
  logic [15:0] mdl_rd, mdl_wr, mdl_err;
  logic        last_acc;

  // One clock: advance the model for what happens at the coming edge,
  // score any popped response, then verify flags/counters after the edge.
  task automatic step();
    logic acc, pop, er;
    logic [32:0] e;
    logic [31:0] rd;
    int idx;
    er  = 1'b0;
    idx = 0;
    acc = cmd_valid && (icb_cmd_ready === 1'b1);
    pop = (icb_rsp_valid === 1'b1) && rsp_ready;
    last_acc = acc;
    if (pop) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, no response required", icb_rsp_err, icb_rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({icb_rsp_err, icb_rsp_rdata} !== e)
          $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h", icb_rsp_err, icb_rsp_rdata, e[32], e[31:0]);
        else pass_cnt++;
      end
    end
    if (acc) begin
      er = (cmd_addr % 4 != 0) || (cmd_addr < 32'h0000_1000) || (cmd_addr >= 32'h0000_1000 + 4 * 1024);
      rd = 32'h0;
      if (!er) idx = (cmd_addr - 32'h0000_1000) / 4;
      if (!er && cmd_read) rd = mdl_mem[idx];
      exp_q.push_back({er, rd});
      if (er) begin
        if (mdl_err != 16'hFFFF) mdl_err++;
      end else if (cmd_read) begin
        if (mdl_rd != 16'hFFFF) mdl_rd++;
      end else begin
        if (mdl_wr != 16'hFFFF) mdl_wr++;
      end
    end
    if (bd_we) mdl_mem[bd_idx] = bd_wdata;
    if (acc && !er && !cmd_read)
      for (int b = 0; b < 4; b++)
        if (cmd_wmask[b]) mdl_mem[idx][8*b +: 8] = cmd_wdata[8*b +: 8];
    @(posedge nice_clk);
    #1;
    bd_we = 1'b0;
    check_cnt++;
    if (icb_rsp_valid !== (exp_q.size() != 0))
      $display("FAIL rsp_valid: got %0b, required %0b", icb_rsp_valid, exp_q.size() != 0);
    else pass_cnt++;
    check_cnt++;
    if (icb_cmd_ready !== (exp_q.size() < 2))
      $display("FAIL cmd_ready: got %0b, required %0b", icb_cmd_ready, exp_q.size() < 2);
    else pass_cnt++;
    check_cnt++;
    if ({rd_cnt, wr_cnt, err_cnt} !== {mdl_rd, mdl_wr, mdl_err})
      $display("FAIL counters: got rd=%0d wr=%0d err=%0d, required rd=%0d wr=%0d err=%0d",
               rd_cnt, wr_cnt, err_cnt, mdl_rd, mdl_wr, mdl_err);
    else pass_cnt++;
  endtask

  task automatic bd_write(input int idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = 10'(idx); bd_wdata = data;
    step();
  endtask

  task automatic issue(input logic rd, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wd; cmd_wmask = wm;
  endtask

  task automatic drain();
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) step();
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    nice_rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wmask = 4'h0;
    rsp_ready = 1'b1; bd_we = 1'b0; bd_idx = 10'h0; bd_wdata = 32'h0;
    mdl_rd = 16'h0; mdl_wr = 16'h0; mdl_err = 16'h0;
    #1 nice_rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({icb_rsp_valid, icb_rsp_err, icb_cmd_ready} !== 3'b001)
      $display("FAIL reset_flags: got valid=%0b err=%0b ready=%0b, required 0 0 1", icb_rsp_valid, icb_rsp_err, icb_cmd_ready);
    else pass_cnt++;
    check_cnt++;
    if (icb_rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", icb_rsp_rdata);
    else pass_cnt++;
    check_cnt++;
    if ({rd_cnt, wr_cnt, err_cnt} !== 48'h0) $display("FAIL reset_counters: got %h, required 0", {rd_cnt, wr_cnt, err_cnt});
    else pass_cnt++;
    repeat (3) @(posedge nice_clk);
    #1 nice_rst_n = 1'b1;
    step();
  endtask

  task automatic test_preload_read();
    bd_write(0, 32'h1122_3344);
    issue(1'b1, 32'h0000_1000, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    check_cnt++;
    if ({icb_rsp_valid, icb_rsp_err, icb_rsp_rdata} !== {2'b10, 32'h1122_3344})
      $display("FAIL preload_read: got valid=%0b err=%0b rdata=%h, required 1 0 11223344", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
    else pass_cnt++;
    check_cnt++;
    if (rd_cnt !== 16'd1) $display("FAIL preload_rd_cnt: got %0d, required 1", rd_cnt);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_masked_write();
    bd_write(1, 32'h0000_0000);
    issue(1'b0, 32'h0000_1004, 32'hAABB_CCDD, 4'b0101);
    step();
    issue(1'b1, 32'h0000_1004, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    check_cnt++;
    if (icb_rsp_rdata !== 32'h00BB_00DD) $display("FAIL masked_write: got %h, required 00bb00dd", icb_rsp_rdata);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic        rds [3];
    addrs[0] = 32'h0000_1002; rds[0] = 1'b1;
    addrs[1] = 32'h0000_0FFC; rds[1] = 1'b0;
    addrs[2] = 32'h0000_2000; rds[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(rds[i], addrs[i], 32'hDEAD_BEEF, 4'hF);
      step();
      cmd_valid = 1'b0;
      check_cnt++;
      if ({icb_rsp_err, icb_rsp_rdata} !== {1'b1, 32'h0})
        $display("FAIL err_case%0d: got err=%0b rdata=%h, required err=1 rdata=0", i, icb_rsp_err, icb_rsp_rdata);
      else pass_cnt++;
      drain();
    end
    check_cnt++;
    if (err_cnt !== 16'd3) $display("FAIL err_cnt: got %0d, required 3", err_cnt);
    else pass_cnt++;
    issue(1'b1, 32'h0000_1000, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    check_cnt++;
    if (icb_rsp_rdata !== 32'h1122_3344) $display("FAIL err_mem_unchanged: got %h, required 11223344", icb_rsp_rdata);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    bd_write(2, 32'd1);
    bd_write(3, 32'd2);
    bd_write(4, 32'd3);
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_1008, 32'h0, 4'h0);
    step();
    issue(1'b1, 32'h0000_100C, 32'h0, 4'h0);
    step();
    check_cnt++;
    if (icb_cmd_ready !== 1'b0) $display("FAIL bp_full_ready: got %0b, required 0", icb_cmd_ready);
    else pass_cnt++;
    issue(1'b1, 32'h0000_1010, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_cnt++;
      if ({last_acc, icb_rsp_valid, icb_rsp_rdata} !== {2'b01, 32'd1})
        $display("FAIL bp_hold%0d: got acc=%0b valid=%0b rdata=%h, required 0 1 1", i, last_acc, icb_rsp_valid, icb_rsp_rdata);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    step();
    check_cnt++;
    if ({last_acc, icb_cmd_ready, icb_rsp_rdata} !== {2'b01, 32'd2})
      $display("FAIL bp_first_pop: got acc=%0b ready=%0b rdata=%h, required 0 1 2", last_acc, icb_cmd_ready, icb_rsp_rdata);
    else pass_cnt++;
    step();
    check_cnt++;
    if (last_acc !== 1'b1) $display("FAIL bp_third_accept: got %0b, required 1", last_acc);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(i >= 8, 32'h0000_1000 + 32'(4 * (i % 8)), $urandom, 4'hF);
      step();
      check_cnt++;
      if ({last_acc, icb_rsp_valid} !== 2'b11)
        $display("FAIL b2b_cycle%0d: got acc=%0b valid=%0b, required 1 1", i, last_acc, icb_rsp_valid);
      else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_random();
    int r, k;
    for (int i = 0; i < 64; i++) bd_write(i, $urandom);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 63);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_read  = $urandom_range(0, 1) == 1;
      cmd_wdata = $urandom;
      cmd_wmask = 4'($urandom_range(0, 15));
      case (r)
        0:       cmd_addr = 32'h0000_1000 + 32'(4 * k) + 32'($urandom_range(1, 3));
        1:       cmd_addr = 32'h0000_1000 - 32'(4 * $urandom_range(1, 8));
        2:       cmd_addr = 32'h0000_2000 + 32'(4 * k);
        default: cmd_addr = 32'h0000_1000 + 32'(4 * k);
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        bd_we    = 1'b1;
        bd_idx   = ($urandom_range(0, 1) == 1) ? 10'(k) : 10'($urandom_range(0, 63));
        bd_wdata = $urandom;
      end
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    issue(1'b1, 32'h0000_1004, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    nice_rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({icb_rsp_valid, icb_cmd_ready} !== 2'b01)
      $display("FAIL midreset_flags: got valid=%0b ready=%0b, required 0 1", icb_rsp_valid, icb_cmd_ready);
    else pass_cnt++;
    check_cnt++;
    if ({rd_cnt, wr_cnt, err_cnt} !== 48'h0) $display("FAIL midreset_counters: got %h, required 0", {rd_cnt, wr_cnt, err_cnt});
    else pass_cnt++;
    exp_q.delete();
    mdl_rd = 16'h0; mdl_wr = 16'h0; mdl_err = 16'h0;
    @(posedge nice_clk);
    #1 nice_rst_n = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b1, 32'h0000_1000, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    check_cnt++;
    if (icb_rsp_rdata !== mdl_mem[0]) $display("FAIL midreset_retained: got %h, required %h", icb_rsp_rdata, mdl_mem[0]);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_masked_write();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/nice_icb_mem_responder.md
# nice_icb_mem_responder

ICB slave that answers the NICE core's memory channel (`nice_icb_cmd_*` / `nice_icb_rsp_*`). It replaces the one-line ACK stub in the NICE-level simulation with a word-addressed SRAM, in-order responses, response backpressure and error signalling. It sits between `e203_subsys_nice_core` and the memory side of the subsystem or bench. It also exposes a backdoor preload port and event counters for verification.

## Interface
- `DEPTH_WORDS`, 1024: SRAM depth in 32-bit words; power of two, at least 2.
- `BASE_ADDR`, 32'h0000_1000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `RSP_FIFO_DEPTH`, 2: response queue entries; at least 2.
- `nice_clk`  in  1  clock.
- `nice_rst_n`  in  1  asynchronous, active-low reset.
- `icb_cmd_valid`  in  1  command valid.
- `icb_cmd_ready`  out  1  command accepted when high together with `icb_cmd_valid`.
- `icb_cmd_addr`  in  32  byte address.
- `icb_cmd_read`  in  1  1 = read, 0 = write.
- `icb_cmd_wdata`  in  32  write data.
- `icb_cmd_wmask`  in  4  byte enables; bit i covers bits [8i+7:8i].
- `icb_rsp_valid`  out  1  response valid.
- `icb_rsp_ready`  in  1  response consumed when high together with `icb_rsp_valid`.
- `icb_rsp_rdata`  out  32  read data; 0 for writes and errors.
- `icb_rsp_err`  out  1  error flag.
- `bd_we`  in  1  backdoor word write.
- `bd_idx`  in  $clog2(DEPTH_WORDS)  backdoor word index.
- `bd_wdata`  in  32  backdoor data; full word, no mask.
- `rd_cnt`, `wr_cnt`, `err_cnt`  out  16 each  saturating event counters.

## Operation
- Command accept: accept = `icb_cmd_valid & icb_cmd_ready`.
  - `icb_cmd_ready` = (`occ` < `RSP_FIFO_DEPTH`), where `occ` is the registered queue occupancy.
  - `icb_cmd_ready` has no combinational path from `icb_rsp_ready`.
- Error decode:
  - err = (addr[1:0] != 0) or (addr < `BASE_ADDR`) or (addr >= `BASE_ADDR` + 4*`DEPTH_WORDS`).
  - Word index = (addr − `BASE_ADDR`) >> 2.
- Read, no error: the SRAM word is read at the accept edge, and {rdata = word, err = 0} is pushed.
- Write, no error: bytes with wmask=1 are updated at the accept edge, and {rdata = 0, err = 0} is pushed.
  - wmask = 0 is legal: no change, normal response.
- Error (read or write): no SRAM access; {rdata = 0, err = 1} is pushed.
- Ordering: responses leave strictly in acceptance order, from a circular FIFO whose pointers wrap modulo `RSP_FIFO_DEPTH`.
- `occ` update:
  - +1 on push only; −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Backdoor write: `bd_we` writes `bd_wdata` to `bd_idx` at the edge.
  - On the same edge as an accepted ICB write to the same word, the ICB write wins for its enabled bytes; the backdoor supplies the remaining bytes.
  - A same-edge ICB read of that word returns the pre-edge value.
- Counters:
  - `rd_cnt` +1 per accepted non-error read.
  - `wr_cnt` +1 per accepted non-error write.
  - `err_cnt` +1 per accepted error command.
  - Each saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync release):
  - `icb_rsp_valid`=0, `icb_rsp_rdata`=0, `icb_rsp_err`=0, `icb_cmd_ready`=1.
  - `occ`=0, pointers=0, counters=0.
  - SRAM contents are not reset; they are retained.
- Latency: command accepted at edge N → `icb_rsp_valid`=1 from edge N+1, provided the queue was empty.
- Throughput: with `icb_rsp_ready` held high, one command per cycle is sustained and `occ` stays at 1.
- Backpressure:
  - `icb_rsp_valid`, `icb_rsp_rdata` and `icb_rsp_err` are held stable until the pop.
  - `icb_cmd_ready` drops the cycle after `occ` reaches `RSP_FIFO_DEPTH`.
  - `icb_cmd_ready` rises again the cycle after a pop from full.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1.
- Reset mid-operation: queued responses are discarded. No response is ever issued for commands accepted before reset.

## Test plan
- Preload via backdoor: idx 0 = 32'h1122_3344. Read addr 32'h1000 → rsp the next cycle, rdata 32'h1122_3344, err 0; `rd_cnt`=1.
- Masked write addr 32'h1004, wdata 32'hAABB_CCDD, wmask 4'b0101, over a backdoor-preloaded 0, then read 32'h1004 → rdata 32'h00BB_00DD.
- Error cases, each → err 1, rdata 0, memory unchanged, `err_cnt`=3:
  - read addr 32'h1002 (misaligned);
  - write addr 32'h0FFC (below base);
  - read addr 32'h2000 (above range, DEPTH 1024).
- Backpressure: hold `icb_rsp_ready`=0 and issue 3 reads (values 1, 2, 3).
  - Two are accepted, then `icb_cmd_ready`=0 and the first rsp (rdata 1) stays stable for 5 cycles.
  - Release `icb_rsp_ready` → responses 1, 2, 3 in order, and the third command is accepted the cycle after the first pop.
- Back-to-back: 8 writes then 8 reads at 32'h1000 + 4i, with `icb_rsp_ready`=1 → 1 response per cycle, data matches.
  - Assert `nice_rst_n`=0 for 1 cycle with 1 rsp pending → `icb_rsp_valid`=0 immediately and counters reset; a subsequent read returns the retained SRAM data.
